// File: rtl/button_toggle_bank.sv
// Multi-channel button front end: sync, debounce, edge-detect, per-channel LED mode.
// Optional LONG_PRESS_EN adds per-channel long-press detection and LED clear.

module button_toggle_ch #(
    parameter int DB_CYCLES   = 240000,
    parameter int LONG_CYCLES = 12000000,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       btn,
    input  logic [1:0] mode,
    output logic       led,
    output logic       press,
    output logic       long_pulse
);
    localparam int CW  = $clog2(DB_CYCLES);
    localparam bit POL = (ACTIVE_LOW != 0);

    logic          s1, s2, stb, stb_q;
    logic [CW-1:0] cnt;
    logic          rise, fall, led_d;
    logic          long_hit, long_rel;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            stb   <= 1'b0;
            stb_q <= 1'b0;
            cnt   <= '0;
            led   <= 1'b0;
            press <= 1'b0;
        end else begin
            s1    <= btn ^ POL;
            s2    <= s1;
            stb_q <= stb;
            press <= rise;
            led   <= led_d;
            // Any return of s2 to stb restarts the window
            if (s2 == stb) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                stb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = stb & ~stb_q;
    assign fall = ~stb & stb_q;

`ifdef LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);
    logic [LW-1:0] lcnt;
    logic          long_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lcnt   <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= long_hit;
            if (!stb)
                lcnt <= '0;
            else if (lcnt != LW'(LONG_CYCLES))
                lcnt <= lcnt + 1'b1;
        end
    end

    assign long_hit   = stb && (lcnt == LW'(LONG_CYCLES - 1));
    // Counter is still saturated on the fall cycle, which marks a long release
    assign long_rel   = (lcnt == LW'(LONG_CYCLES));
    assign long_pulse = long_q;
`else
    assign long_hit   = 1'b0;
    assign long_rel   = 1'b0;
    assign long_pulse = 1'b0;
`endif

    always_comb begin
        led_d = led;
        case (mode)
            2'b01:   led_d = stb;
            2'b10:   if (fall && !long_rel) led_d = ~led;
            default: if (rise) led_d = ~led;
        endcase
        if (long_hit && mode != 2'b01)
            led_d = 1'b0;
    end
endmodule

module button_toggle_bank #(
    parameter int N_CH        = 4,
    parameter int DB_CYCLES   = 240000,
    parameter int LONG_CYCLES = 12000000,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [N_CH-1:0]   BTN,
    input  logic [2*N_CH-1:0] MODE,
    output logic [N_CH-1:0]   LED,
    output logic [N_CH-1:0]   PRESS,
    output logic [N_CH-1:0]   LONG
);
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        button_toggle_ch #(
            .DB_CYCLES  (DB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .CLK       (CLK),
            .RST_N     (RST_N),
            .btn       (BTN[g]),
            .mode      (MODE[2*g +: 2]),
            .led       (LED[g]),
            .press     (PRESS[g]),
            .long_pulse(LONG[g])
        );
    end
endmodule

// File: tb/tb_button_toggle_bank.sv
// Directed bench for button_toggle_bank (DB_CYCLES=4, LONG_CYCLES=16, N_CH=4).
// Loop index t is the spec edge number: t=0 is the edge that captures the BTN change.

module tb_button_toggle_bank;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn0, btn1;
    logic [7:0] mode;
    logic [3:0] led0, press0, long0, led1, press1, long1;
    int         n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    button_toggle_bank #(.N_CH(4), .DB_CYCLES(4), .LONG_CYCLES(16), .ACTIVE_LOW(0)) dut0 (
        .CLK(clk), .RST_N(rst_n), .BTN(btn0), .MODE(mode),
        .LED(led0), .PRESS(press0), .LONG(long0)
    );
    button_toggle_bank #(.N_CH(4), .DB_CYCLES(4), .LONG_CYCLES(16), .ACTIVE_LOW(1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .BTN(btn1), .MODE(mode),
        .LED(led1), .PRESS(press1), .LONG(long1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        btn0  = 4'h0;
        btn1  = 4'hF;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        int pc, p1, p2, bad, r2, f2, r3, e2, e3, lc, le;
`ifdef LONG_PRESS_EN
        localparam bit LP = 1'b1;
`else
        localparam bit LP = 1'b0;
`endif
        // ch0/ch1 TOGGLE, ch2 MOMENTARY, ch3 RELEASE_TOGGLE
        mode  = 8'b10_01_00_00;
        rst_n = 1'b0;
        btn0  = 4'h0;
        btn1  = 4'hF;
        tick;
        chk("reset dut0", int'({led0, press0, long0}), 0);
        chk("reset dut1", int'({led1, press1, long1}), 0);
        rst_n = 1'b1;
        tick;

        // ch0 TOGGLE: high 20, low 20, high 20
        pc = 0; p1 = -1; p2 = -1;
        for (int t = 0; t < 60; t++) begin
            btn0[0] = (t < 20) || (t >= 40);
            tick;
            if (press0[0]) begin
                pc++;
                if (p1 < 0) p1 = t; else p2 = t;
            end
            if (t == 5)  chk("t1 led before press", int'(led0[0]), 0);
            if (t == 6)  chk("t1 led after press", int'(led0[0]), 1);
            if (t == 7)  chk("t1 press deassert", int'(press0[0]), 0);
            // A long press (t=21) clears LED when the feature is on
            if (t == 35) chk("t1 led after release", int'(led0[0]), LP ? 0 : 1);
            if (t == 46) chk("t1 led second press", int'(led0[0]), LP ? 1 : 0);
        end
        chk("t1 press count", pc, 2);
        chk("t1 press1 edge", p1, 6);
        chk("t1 press2 edge", p2, 46);

        // ch1 glitches: 3 high, 5 low, x10
        do_reset;
        bad = 0;
        for (int t = 0; t < 80; t++) begin
            btn0[1] = (t % 8) < 3;
            tick;
            if (press0[1] || led0[1]) bad++;
        end
        chk("t2 glitch outputs", bad, 0);

        // ch2 MOMENTARY + ch3 RELEASE_TOGGLE pressed together for 30 cycles
        do_reset;
        r2 = -1; f2 = -1; r3 = -1; e2 = -1; e3 = -1;
        for (int t = 0; t < 50; t++) begin
            btn0[3:2] = (t < 30) ? 2'b11 : 2'b00;
            tick;
            if (led0[2] && r2 < 0) r2 = t;
            if (!led0[2] && r2 >= 0 && f2 < 0) f2 = t;
            if (led0[3] && r3 < 0) r3 = t;
            if (press0[2] && e2 < 0) e2 = t;
            if (press0[3] && e3 < 0) e3 = t;
            if (t == 20) chk("t3 led3 held", int'(led0[3]), 0);
        end
        chk("t3 led2 rise", r2, 6);
        chk("t3 led2 fall", f2, 36);
        chk("t3 press2 edge", e2, 6);
        chk("t3 press3 edge", e3, 6);
        // A long release does not toggle when the feature is on
        chk("t3 led3 rise", r3, LP ? -1 : 36);

        // Reset mid-debounce; LED[3] is 1 here in the default build
        btn0[0] = 1'b1;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        chk("t5 reset async clear", int'({led0, press0, long0}), 0);
        tick;
        tick;
        tick;
        chk("t5 reset held", int'({led0, press0, long0}), 0);
        rst_n = 1'b1;
        pc = 0; p1 = -1;
        for (int t = 0; t < 12; t++) begin
            tick;
            if (press0[0]) begin
                pc++;
                if (p1 < 0) p1 = t;
            end
        end
        chk("t5 press edge", p1, 6);
        chk("t5 press count", pc, 1);

        // ACTIVE_LOW ch0: pin idle high, low for 20 cycles
        do_reset;
        pc = 0; p1 = -1;
        for (int t = 0; t < 30; t++) begin
            btn1[0] = !(t < 20);
            tick;
            if (press1[0]) begin
                pc++;
                if (p1 < 0) p1 = t;
            end
            if (t == 15) chk("t4 led mid", int'(led1[0]), 1);
        end
        chk("t4 press count", pc, 1);
        chk("t4 press edge", p1, 6);
        chk("t4 led end", int'(led1[0]), LP ? 0 : 1);

        // Long press: ch0 TOGGLE held 40 cycles
        do_reset;
        lc = 0; le = -1;
        for (int t = 0; t < 50; t++) begin
            btn0[0] = (t < 40);
            tick;
            if (long0[0]) begin
                lc++;
                if (le < 0) le = t;
            end
            if (t == 6)  chk("t6 led after press", int'(led0[0]), 1);
            if (t == 25) chk("t6 led after long", int'(led0[0]), LP ? 0 : 1);
            if (t == 49) chk("t6 led after release", int'(led0[0]), LP ? 0 : 1);
        end
        chk("t6 long count", lc, LP ? 1 : 0);
        chk("t6 long edge", le, LP ? 21 : -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
